// File: rtl/pebble_pkg.sv
// Shared definitions for the pebble core front end: fetch state encoding and
// default address/instruction widths used by fetch, instruction memory and decode.
package pebble_pkg;

  localparam int unsigned ADDR_WIDTH = 10;
  localparam int unsigned DATA_WIDTH = 9;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HALTED
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-to-decode valid/ready handshake carrying the instruction and its address.
interface fetch_unit_if #(
  parameter int unsigned ADDR_WIDTH = pebble_pkg::ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = pebble_pkg::DATA_WIDTH
);

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_instr;
  logic [ADDR_WIDTH-1:0] out_pc;

  modport master (output out_valid, output out_instr, output out_pc, input out_ready);
  modport slave  (input out_valid, input out_instr, input out_pc, output out_ready);

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, addresses the combinational instruction
// memory, registers the returned instruction and hands it to decode.
module fetch_unit #(
  parameter int unsigned ADDR_WIDTH = pebble_pkg::ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = pebble_pkg::DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_instr,
  fetch_unit_if.master          dec,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  input  logic                  halt,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  fetch_count
);

  import pebble_pkg::*;

  fetch_state_t          state;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  handshake;

  assign imem_addr = pc;
  assign handshake = dec.out_valid && dec.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      dec.out_valid <= 1'b0;
      dec.out_instr <= '0;
      dec.out_pc    <= '0;
      done          <= 1'b0;
      fetch_count   <= '0;
    end else begin
      // A handshake counts even when a branch flushes it in the same cycle.
      if (handshake && (fetch_count != '1)) begin
        fetch_count <= fetch_count + 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state <= FETCH;
            pc    <= RESET_PC;
          end
        end

        FETCH: begin
          if (halt) begin
            state         <= HALTED;
            dec.out_valid <= 1'b0;
            done          <= 1'b1;
          end else if (branch_taken) begin
            pc            <= branch_target;
            dec.out_valid <= 1'b0;
          end else if (!dec.out_valid || dec.out_ready) begin
            dec.out_instr <= imem_instr;
            dec.out_pc    <= pc;
            dec.out_valid <= 1'b1;
            pc            <= pc + 1'b1;
          end
        end

        HALTED: begin
          if (start) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            done        <= 1'b0;
            fetch_count <= '0;
          end
        end

        default: begin
          state         <= IDLE;
          dec.out_valid <= 1'b0;
          done          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a combinational instruction memory.
module tb_fetch_unit;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [9:0] imem_addr;
  logic [8:0] imem_instr;
  logic       branch_taken;
  logic [9:0] branch_target;
  logic       halt;
  logic       done;
  logic [15:0] fetch_count;

  int n_checks;
  int n_fail;

  fetch_unit_if #(.ADDR_WIDTH(10), .DATA_WIDTH(9)) dec ();

  fetch_unit #(
    .ADDR_WIDTH(10),
    .DATA_WIDTH(9),
    .RESET_PC  (10'h000),
    .CNT_WIDTH (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .imem_addr    (imem_addr),
    .imem_instr   (imem_instr),
    .dec          (dec),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .halt         (halt),
    .done         (done),
    .fetch_count  (fetch_count)
  );

  // Memory contents: low addresses hold addr+1; the upper half adds 0x0AA so
  // 0x200 reads 0x0AB and 0x3FF reads 0x0AA.
  function automatic logic [8:0] mem_word(input logic [9:0] a);
    return a[8:0] + 9'd1 + (a[9] ? 9'h0AA : 9'h000);
  endfunction

  assign imem_instr = mem_word(imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; halt = 1'b0; branch_taken = 1'b0;
    branch_target = '0; dec.out_ready = 1'b1;
    #12;
    n_checks++; if (dec.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0h want 0", dec.out_valid); end
    n_checks++; if (dec.out_instr !== 9'h000) begin n_fail++; $display("FAIL rst_instr: got %0h want 0", dec.out_instr); end
    n_checks++; if (dec.out_pc !== 10'h000) begin n_fail++; $display("FAIL rst_pc: got %0h want 0", dec.out_pc); end
    n_checks++; if (imem_addr !== 10'h000) begin n_fail++; $display("FAIL rst_addr: got %0h want 0", imem_addr); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %0h want 0", done); end
    n_checks++; if (fetch_count !== 16'h0) begin n_fail++; $display("FAIL rst_count: got %0h want 0", fetch_count); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++; if (dec.out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid: got %0h want 0", dec.out_valid); end
  endtask

  task automatic test_start_stream();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++; if (dec.out_valid !== 1'b0) begin n_fail++; $display("FAIL start_t1_valid: got %0h want 0", dec.out_valid); end
    n_checks++; if (imem_addr !== 10'h000) begin n_fail++; $display("FAIL start_t1_addr: got %0h want 0", imem_addr); end
    tick();
    n_checks++; if (dec.out_valid !== 1'b1) begin n_fail++; $display("FAIL start_t2_valid: got %0h want 1", dec.out_valid); end
    n_checks++; if (dec.out_instr !== 9'h001) begin n_fail++; $display("FAIL seq0_instr: got %0h want 001", dec.out_instr); end
    n_checks++; if (dec.out_pc !== 10'h000) begin n_fail++; $display("FAIL seq0_pc: got %0h want 000", dec.out_pc); end
    tick();
    n_checks++; if (dec.out_instr !== 9'h002) begin n_fail++; $display("FAIL seq1_instr: got %0h want 002", dec.out_instr); end
    n_checks++; if (dec.out_pc !== 10'h001) begin n_fail++; $display("FAIL seq1_pc: got %0h want 001", dec.out_pc); end
    tick();
    n_checks++; if (dec.out_instr !== 9'h003) begin n_fail++; $display("FAIL seq2_instr: got %0h want 003", dec.out_instr); end
    n_checks++; if (dec.out_pc !== 10'h002) begin n_fail++; $display("FAIL seq2_pc: got %0h want 002", dec.out_pc); end
    tick();
    n_checks++; if (dec.out_instr !== 9'h004) begin n_fail++; $display("FAIL seq3_instr: got %0h want 004", dec.out_instr); end
    n_checks++; if (dec.out_pc !== 10'h003) begin n_fail++; $display("FAIL seq3_pc: got %0h want 003", dec.out_pc); end
    n_checks++; if (fetch_count !== 16'd3) begin n_fail++; $display("FAIL seq_count: got %0d want 3", fetch_count); end
  endtask

  task automatic test_stall();
    dec.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (dec.out_instr !== 9'h004) begin n_fail++; $display("FAIL stall_instr[%0d]: got %0h want 004", i, dec.out_instr); end
      n_checks++; if (dec.out_pc !== 10'h003) begin n_fail++; $display("FAIL stall_pc[%0d]: got %0h want 003", i, dec.out_pc); end
      n_checks++; if (imem_addr !== 10'h004) begin n_fail++; $display("FAIL stall_addr[%0d]: got %0h want 004", i, imem_addr); end
      n_checks++; if (fetch_count !== 16'd3) begin n_fail++; $display("FAIL stall_count[%0d]: got %0d want 3", i, fetch_count); end
    end
    dec.out_ready = 1'b1;
    tick();
    n_checks++; if (dec.out_instr !== 9'h005) begin n_fail++; $display("FAIL resume_instr: got %0h want 005", dec.out_instr); end
    n_checks++; if (dec.out_pc !== 10'h004) begin n_fail++; $display("FAIL resume_pc: got %0h want 004", dec.out_pc); end
    n_checks++; if (fetch_count !== 16'd4) begin n_fail++; $display("FAIL resume_count: got %0d want 4", fetch_count); end
    tick();
    n_checks++; if (dec.out_pc !== 10'h005) begin n_fail++; $display("FAIL resume2_pc: got %0h want 005", dec.out_pc); end
  endtask

  task automatic test_branch();
    branch_taken = 1'b1; branch_target = 10'h200;
    tick();
    branch_taken = 1'b0; branch_target = 10'h000;
    n_checks++; if (dec.out_valid !== 1'b0) begin n_fail++; $display("FAIL br_bubble_valid: got %0h want 0", dec.out_valid); end
    n_checks++; if (imem_addr !== 10'h200) begin n_fail++; $display("FAIL br_addr: got %0h want 200", imem_addr); end
    n_checks++; if (fetch_count !== 16'd6) begin n_fail++; $display("FAIL br_count: got %0d want 6", fetch_count); end
    tick();
    n_checks++; if (dec.out_valid !== 1'b1) begin n_fail++; $display("FAIL br_tgt_valid: got %0h want 1", dec.out_valid); end
    n_checks++; if (dec.out_pc !== 10'h200) begin n_fail++; $display("FAIL br_tgt_pc: got %0h want 200", dec.out_pc); end
    n_checks++; if (dec.out_instr !== 9'h0AB) begin n_fail++; $display("FAIL br_tgt_instr: got %0h want 0ab", dec.out_instr); end
  endtask

  task automatic test_wrap();
    branch_taken = 1'b1; branch_target = 10'h3FF;
    tick();
    branch_taken = 1'b0;
    n_checks++; if (fetch_count !== 16'd7) begin n_fail++; $display("FAIL wrap_count: got %0d want 7", fetch_count); end
    tick();
    n_checks++; if (dec.out_pc !== 10'h3FF) begin n_fail++; $display("FAIL wrap_pc_top: got %0h want 3ff", dec.out_pc); end
    n_checks++; if (dec.out_instr !== 9'h0AA) begin n_fail++; $display("FAIL wrap_instr_top: got %0h want 0aa", dec.out_instr); end
    tick();
    n_checks++; if (dec.out_pc !== 10'h000) begin n_fail++; $display("FAIL wrap_pc_zero: got %0h want 000", dec.out_pc); end
    n_checks++; if (dec.out_instr !== 9'h001) begin n_fail++; $display("FAIL wrap_instr_zero: got %0h want 001", dec.out_instr); end
    n_checks++; if (imem_addr !== 10'h001) begin n_fail++; $display("FAIL wrap_addr: got %0h want 001", imem_addr); end
  endtask

  task automatic test_halt_restart();
    halt = 1'b1; branch_taken = 1'b1; branch_target = 10'h100;
    tick();
    halt = 1'b0;
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL halt_done: got %0h want 1", done); end
    n_checks++; if (dec.out_valid !== 1'b0) begin n_fail++; $display("FAIL halt_valid: got %0h want 0", dec.out_valid); end
    n_checks++; if (imem_addr !== 10'h001) begin n_fail++; $display("FAIL halt_addr: got %0h want 001", imem_addr); end
    n_checks++; if (fetch_count !== 16'd9) begin n_fail++; $display("FAIL halt_count: got %0d want 9", fetch_count); end
    tick();
    branch_taken = 1'b0;
    n_checks++; if (imem_addr !== 10'h001) begin n_fail++; $display("FAIL halted_br_addr: got %0h want 001", imem_addr); end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL halted_done: got %0h want 1", done); end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL restart_done: got %0h want 0", done); end
    n_checks++; if (fetch_count !== 16'd0) begin n_fail++; $display("FAIL restart_count: got %0d want 0", fetch_count); end
    n_checks++; if (imem_addr !== 10'h000) begin n_fail++; $display("FAIL restart_addr: got %0h want 000", imem_addr); end
    tick();
    n_checks++; if (dec.out_pc !== 10'h000) begin n_fail++; $display("FAIL restart_pc: got %0h want 000", dec.out_pc); end
    n_checks++; if (dec.out_valid !== 1'b1) begin n_fail++; $display("FAIL restart_valid: got %0h want 1", dec.out_valid); end
    tick();
    n_checks++; if (fetch_count !== 16'd1) begin n_fail++; $display("FAIL restart_count1: got %0d want 1", fetch_count); end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++; if (dec.out_pc !== 10'h002) begin n_fail++; $display("FAIL start_in_fetch_pc: got %0h want 002", dec.out_pc); end
    n_checks++; if (dec.out_instr !== 9'h003) begin n_fail++; $display("FAIL start_in_fetch_instr: got %0h want 003", dec.out_instr); end
  endtask

  task automatic test_async_reset();
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++; if (dec.out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %0h want 0", dec.out_valid); end
    n_checks++; if (dec.out_pc !== 10'h000) begin n_fail++; $display("FAIL arst_pc: got %0h want 000", dec.out_pc); end
    n_checks++; if (dec.out_instr !== 9'h000) begin n_fail++; $display("FAIL arst_instr: got %0h want 000", dec.out_instr); end
    n_checks++; if (fetch_count !== 16'd0) begin n_fail++; $display("FAIL arst_count: got %0d want 0", fetch_count); end
    n_checks++; if (imem_addr !== 10'h000) begin n_fail++; $display("FAIL arst_addr: got %0h want 000", imem_addr); end
    start = 1'b1;
    tick();
    tick();
    n_checks++; if (dec.out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_start_valid: got %0h want 0", dec.out_valid); end
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++; if (dec.out_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_idle: got %0h want 0", dec.out_valid); end
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++; if (dec.out_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_t1: got %0h want 0", dec.out_valid); end
    tick();
    n_checks++; if (dec.out_instr !== 9'h001) begin n_fail++; $display("FAIL post_rst_instr0: got %0h want 001", dec.out_instr); end
    n_checks++; if (dec.out_pc !== 10'h000) begin n_fail++; $display("FAIL post_rst_pc0: got %0h want 000", dec.out_pc); end
    tick();
    n_checks++; if (dec.out_instr !== 9'h002) begin n_fail++; $display("FAIL post_rst_instr1: got %0h want 002", dec.out_instr); end
    n_checks++; if (fetch_count !== 16'd1) begin n_fail++; $display("FAIL post_rst_count: got %0d want 1", fetch_count); end
  endtask

  task automatic test_saturation();
    // Count is 1 on entry; each further cycle with out_ready=1 adds one.
    for (int i = 0; i < 65533; i++) begin
      tick();
    end
    n_checks++; if (fetch_count !== 16'hFFFE) begin n_fail++; $display("FAIL sat_pre: got %0h want fffe", fetch_count); end
    tick();
    n_checks++; if (fetch_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_max: got %0h want ffff", fetch_count); end
    tick();
    tick();
    n_checks++; if (fetch_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %0h want ffff", fetch_count); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_start_stream();
    test_stall();
    test_branch();
    test_wrap();
    test_halt_restart();
    test_async_reset();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
